// File: rtl/updown_pkg.sv
// Shared definitions for the lab counter family: direction/bank encodings and
// the modular step helper that later counter blocks reuse.
package updown_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam logic BANK0    = 1'b0;
  localparam logic BANK1    = 1'b1;

  // Widest counter the helper supports; narrower counters zero-extend into it.
  localparam int ARITH_W = 32;

  // Returns {wrap, value}. The step is first reduced modulo the modulus, so a
  // step that is a whole multiple of the modulus leaves the value unchanged.
  function automatic logic [ARITH_W:0] mod_step(
    input logic [ARITH_W-1:0] cur,
    input logic [ARITH_W-1:0] stp,
    input logic [ARITH_W:0]   modulus,
    input logic               dn
  );
    logic [ARITH_W:0]   s;
    logic [ARITH_W:0]   acc;
    logic [ARITH_W-1:0] res;
    logic               wr;
    s   = {1'b0, stp} % modulus;
    wr  = 1'b0;
    acc = '0;
    if (dn == DIR_UP) begin
      acc = {1'b0, cur} + s;
      if (acc >= modulus) begin
        res = ARITH_W'(acc - modulus);
        wr  = 1'b1;
      end else begin
        res = ARITH_W'(acc);
      end
    end else begin
      if ({1'b0, cur} < s) begin
        res = ARITH_W'({1'b0, cur} + modulus - s);
        wr  = 1'b1;
      end else begin
        res = ARITH_W'({1'b0, cur} - s);
      end
    end
    return {wr, res};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a count-enable tick once every PRESCALE clocks;
// clr restarts the period so the next tick lands PRESCALE clocks later.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pre_q;
  logic [CW-1:0] pre_d;

  assign tick = (pre_q == LAST);

  always_comb begin
    pre_d = pre_q + CW'(1);
    if (clr || tick) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down modulo counter with prescaled tick, load/hold and a
// registered mirror of the count onto one of two LED banks.
module updown_counter_param
  import updown_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MOD_MAX  = 255,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             dir,
  input  logic             bank_sel,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] led_bank0,
  output logic [WIDTH-1:0] led_bank1,
  output logic             wrap
);

  localparam logic [ARITH_W:0]   MODULUS = (ARITH_W + 1)'(MOD_MAX) + (ARITH_W + 1)'(1);
  localparam logic [WIDTH-1:0]   MAX_VAL = WIDTH'(MOD_MAX);

  logic             tick;
  logic [ARITH_W:0] stepRes;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic [WIDTH-1:0] led0_q;
  logic [WIDTH-1:0] led1_q;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .tick(tick)
  );

  assign stepRes = mod_step(ARITH_W'(count_q), ARITH_W'(step), MODULUS, dir);

  // Upper helper bits are always zero because the result is below the modulus.
  generate
    if (WIDTH < ARITH_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^stepRes[ARITH_W-1:WIDTH];
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (!hold && tick) begin
      count_d = stepRes[WIDTH-1:0];
      wrap_d  = stepRes[ARITH_W];
    end
  end

  // LED banks copy the previous count, so a bank switch never shows two lit banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      led0_q  <= '0;
      led1_q  <= '0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      led0_q  <= (bank_sel == BANK0) ? count_q : '0;
      led1_q  <= (bank_sel == BANK1) ? count_q : '0;
    end
  end

  assign count     = count_q;
  assign wrap      = wrap_q;
  assign led_bank0 = led0_q;
  assign led_bank1 = led1_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench driving three counter configurations from shared stimulus
// and comparing every output against a behavioural model each clock.
module tb_updown_counter_param;

  typedef struct {
    int count;
    int pre;
    int led0;
    int led1;
    int wrap;
  } model_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       hold;
  logic       dir;
  logic       bankSel;
  logic       load;
  logic [8:0] loadVal;
  logic [8:0] stepVal;

  logic [7:0] countA, led0A, led1A;
  logic [3:0] countB, led0B, led1B;
  logic [8:0] countC, led0C, led1C;
  logic       wrapA, wrapB, wrapC;

  int errors = 0;
  int checks = 0;

  model_t mA, mB, mC;
  model_t qA[$];
  model_t qB[$];
  model_t qC[$];

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(8), .MOD_MAX(255), .PRESCALE(1)) dutA (
    .clk(clk), .rst(rst), .hold(hold), .dir(dir), .bank_sel(bankSel), .load(load),
    .load_val(loadVal[7:0]), .step(stepVal[7:0]), .count(countA),
    .led_bank0(led0A), .led_bank1(led1A), .wrap(wrapA)
  );

  updown_counter_param #(.WIDTH(4), .MOD_MAX(9), .PRESCALE(1)) dutB (
    .clk(clk), .rst(rst), .hold(hold), .dir(dir), .bank_sel(bankSel), .load(load),
    .load_val(loadVal[3:0]), .step(stepVal[3:0]), .count(countB),
    .led_bank0(led0B), .led_bank1(led1B), .wrap(wrapB)
  );

  updown_counter_param #(.WIDTH(9), .MOD_MAX(255), .PRESCALE(4)) dutC (
    .clk(clk), .rst(rst), .hold(hold), .dir(dir), .bank_sel(bankSel), .load(load),
    .load_val(loadVal), .step(stepVal), .count(countC),
    .led_bank0(led0C), .led_bank1(led1C), .wrap(wrapC)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic model_t nextModel(input model_t s, input int width, input int modMax,
                                       input int prescale, input logic h, input logic d,
                                       input logic b, input logic l, input int ldv, input int stp);
    model_t n;
    int mask;
    int lv;
    int sv;
    bit tk;
    n    = s;
    mask = (1 << width) - 1;
    lv   = ldv & mask;
    sv   = (stp & mask) % (modMax + 1);
    tk   = (s.pre == prescale - 1);
    n.led0 = (b == 1'b0) ? s.count : 0;
    n.led1 = (b == 1'b1) ? s.count : 0;
    n.wrap = 0;
    if (l) begin
      n.count = (lv > modMax) ? modMax : lv;
      n.pre   = 0;
    end else begin
      n.pre = tk ? 0 : s.pre + 1;
      if (!h && tk) begin
        if (!d) begin
          if (s.count + sv > modMax) begin
            n.count = s.count + sv - (modMax + 1);
            n.wrap  = 1;
          end else begin
            n.count = s.count + sv;
          end
        end else begin
          if (s.count < sv) begin
            n.count = s.count + (modMax + 1) - sv;
            n.wrap  = 1;
          end else begin
            n.count = s.count - sv;
          end
        end
      end
    end
    return n;
  endfunction

  task automatic checkDut(input string name, input model_t e, input logic [31:0] c,
                          input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] w);
    checkOutput($sformatf("%s.count", name), c, e.count);
    checkOutput($sformatf("%s.led0", name), l0, e.led0);
    checkOutput($sformatf("%s.led1", name), l1, e.led1);
    checkOutput($sformatf("%s.wrap", name), w, e.wrap);
  endtask

  task automatic clearModels();
    mA = '{0, 0, 0, 0, 0};
    mB = '{0, 0, 0, 0, 0};
    mC = '{0, 0, 0, 0, 0};
  endtask

  // One clock of stimulus: predict, push, clock, then pop and compare.
  task automatic applyStimulus(input logic h, input logic d, input logic b, input logic l,
                               input int ldv, input int stp);
    model_t e;
    hold    = h;
    dir     = d;
    bankSel = b;
    load    = l;
    loadVal = 9'(ldv);
    stepVal = 9'(stp);
    mA = nextModel(mA, 8, 255, 1, h, d, b, l, ldv, stp);
    mB = nextModel(mB, 4, 9, 1, h, d, b, l, ldv, stp);
    mC = nextModel(mC, 9, 255, 4, h, d, b, l, ldv, stp);
    qA.push_back(mA);
    qB.push_back(mB);
    qC.push_back(mC);
    @(posedge clk);
    #1;
    e = qA.pop_front();
    checkDut("A", e, 32'(countA), 32'(led0A), 32'(led1A), 32'(wrapA));
    e = qB.pop_front();
    checkDut("B", e, 32'(countB), 32'(led0B), 32'(led1B), 32'(wrapB));
    e = qC.pop_front();
    checkDut("C", e, 32'(countC), 32'(led0C), 32'(led1C), 32'(wrapC));
    @(negedge clk);
  endtask

  // Reset between edges must clear every output without waiting for a clock.
  task automatic asyncResetCheck(input string tag);
    rst = 1'b1;
    #2;
    checkOutput({tag, ".countA"}, 32'(countA), 0);
    checkOutput({tag, ".led0A"}, 32'(led0A), 0);
    checkOutput({tag, ".led1A"}, 32'(led1A), 0);
    checkOutput({tag, ".wrapA"}, 32'(wrapA), 0);
    checkOutput({tag, ".countB"}, 32'(countB), 0);
    checkOutput({tag, ".countC"}, 32'(countC), 0);
    checkOutput({tag, ".led1C"}, 32'(led1C), 0);
    clearModels();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    hold    = 1'b0;
    dir     = 1'b0;
    bankSel = 1'b0;
    load    = 1'b0;
    loadVal = '0;
    stepVal = '0;
    clearModels();
    @(negedge clk);
    @(negedge clk);
    asyncResetCheck("reset");

    // Up wrap with step 1
    applyStimulus(0, 0, 0, 1, 254, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 1);

    // Down wrap with step 3
    applyStimulus(0, 1, 0, 1, 4, 3);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0, 0, 3);

    // Hold, then load overriding hold, then clamped loads
    applyStimulus(0, 0, 0, 1, 10, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 200, 1);
    applyStimulus(1, 0, 0, 1, 300, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Prescaler spacing from reset, then restarted by a mid-period load
    asyncResetCheck("prescaleRst");
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 20, 1);
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 0, 0, 1);

    // Step that is a multiple of the modulus, plus zero step
    applyStimulus(0, 0, 0, 1, 5, 10);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 10);
    applyStimulus(0, 1, 0, 0, 0, 0);

    // Bank switch
    applyStimulus(1, 0, 0, 1, 8'h5A, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);

    // Random mix of all controls
    for (int i = 0; i < 80; i++) begin
      applyStimulus(logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 1)), logic'($urandom_range(0, 9) == 0),
                    int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
    end

    // Reset asserted mid-cycle with a non-zero count
    applyStimulus(0, 0, 1, 1, 8'h5A, 1);
    applyStimulus(0, 0, 1, 0, 0, 1);
    asyncResetCheck("midRst");
    applyStimulus(0, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
